// File: rtl/softmax_sum_acc.sv
// Softmax denominator accumulator: streams single-precision elements through an
// external strobe/ack floating-point adder and reports the final sum and element count.
module softmax_sum_acc #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    input  logic             in_strb,
    output logic             in_ack,
    output logic [31:0]      add_a,
    output logic             add_a_strb,
    input  logic             add_a_ack,
    output logic [31:0]      add_b,
    output logic             add_b_strb,
    input  logic             add_b_ack,
    input  logic [31:0]      add_z,
    input  logic             add_z_strb,
    output logic             add_z_ack,
    output logic [31:0]      sum_z,
    output logic [CNT_W-1:0] sum_count,
    output logic             sum_strb,
    input  logic             sum_ack
);

    // Every port: a transfer happens on the posedge where strb and ack are both 1;
    // the strb side holds data stable until then and drops strb on that same edge.
    typedef enum logic [2:0] {
        GET_X   = 3'd0,
        SEND_A  = 3'd1,
        SEND_B  = 3'd2,
        GET_Z   = 3'd3,
        PUT_SUM = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [31:0]      acc;
    logic [31:0]      x;
    logic             last_r;
    logic [CNT_W-1:0] count;

    logic in_xfer;
    logic a_xfer;
    logic b_xfer;
    logic z_xfer;
    logic sum_xfer;

    assign in_xfer  = in_strb && in_ack;
    assign a_xfer   = add_a_strb && add_a_ack;
    assign b_xfer   = add_b_strb && add_b_ack;
    assign z_xfer   = add_z_strb && add_z_ack;
    assign sum_xfer = sum_strb && sum_ack;

    always_comb begin
        state_next = state;
        case (state)
            GET_X:   if (in_xfer)  state_next = SEND_A;
            SEND_A:  if (a_xfer)   state_next = SEND_B;
            SEND_B:  if (b_xfer)   state_next = GET_Z;
            GET_Z:   if (z_xfer)   state_next = last_r ? PUT_SUM : GET_X;
            PUT_SUM: if (sum_xfer) state_next = GET_X;
            default:               state_next = GET_X;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= GET_X;
        else     state <= state_next;
    end

    // Handshake strobes are registered; each state raises its own and drops it on transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ack     <= 1'b0;
            add_a      <= 32'h0;
            add_a_strb <= 1'b0;
            add_b      <= 32'h0;
            add_b_strb <= 1'b0;
            add_z_ack  <= 1'b0;
            sum_z      <= 32'h0;
            sum_count  <= '0;
            sum_strb   <= 1'b0;
            acc        <= 32'h0;
            x          <= 32'h0;
            last_r     <= 1'b0;
            count      <= '0;
        end else begin
            case (state)
                GET_X: begin
                    in_ack <= 1'b1;
                    if (in_xfer) begin
                        x      <= in_data;
                        last_r <= in_last;
                        in_ack <= 1'b0;
                    end
                end
                SEND_A: begin
                    add_a      <= acc;
                    add_a_strb <= 1'b1;
                    if (a_xfer) add_a_strb <= 1'b0;
                end
                SEND_B: begin
                    add_b      <= x;
                    add_b_strb <= 1'b1;
                    if (b_xfer) add_b_strb <= 1'b0;
                end
                GET_Z: begin
                    add_z_ack <= 1'b1;
                    if (z_xfer) begin
                        acc       <= add_z;
                        count     <= count + CNT_W'(1);
                        add_z_ack <= 1'b0;
                    end
                end
                PUT_SUM: begin
                    sum_z     <= acc;
                    sum_count <= count;
                    sum_strb  <= 1'b1;
                    // The first element of the next vector is added to +0.
                    if (sum_xfer) begin
                        sum_strb <= 1'b0;
                        acc      <= 32'h0;
                        count    <= '0;
                    end
                end
                default: begin
                    in_ack <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_sum_acc.sv
// Bench for softmax_sum_acc: behavioural strobe/ack adder, random sum backpressure,
// and a scoreboard of expected {sum, count} results.
module tb_softmax_sum_acc;

    localparam int CNT_W = 4;
    localparam int SW    = 32 + CNT_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      in_data = 32'h0;
    logic             in_last = 1'b0;
    logic             in_strb = 1'b0;
    logic             in_ack;
    logic [31:0]      add_a;
    logic             add_a_strb;
    logic             add_a_ack = 1'b0;
    logic [31:0]      add_b;
    logic             add_b_strb;
    logic             add_b_ack = 1'b0;
    logic [31:0]      add_z = 32'h0;
    logic             add_z_strb = 1'b0;
    logic             add_z_ack;
    logic [31:0]      sum_z;
    logic [CNT_W-1:0] sum_count;
    logic             sum_strb;
    logic             sum_ack = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic [SW-1:0] exp_q[$];
    logic [SW-1:0] msk_q[$];
    logic          bp_mode = 1'b0;

    softmax_sum_acc #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_last(in_last), .in_strb(in_strb), .in_ack(in_ack),
        .add_a(add_a), .add_a_strb(add_a_strb), .add_a_ack(add_a_ack),
        .add_b(add_b), .add_b_strb(add_b_strb), .add_b_ack(add_b_ack),
        .add_z(add_z), .add_z_strb(add_z_strb), .add_z_ack(add_z_ack),
        .sum_z(sum_z), .sum_count(sum_count), .sum_strb(sum_strb), .sum_ack(sum_ack)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // single <-> double conversion for the behavioural adder (no denormals needed)
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'h00)
            d = {f[31], 63'd0};
        else if (f[30:23] == 8'hff)
            d = (f[22:0] != 0) ? {f[31], 11'h7ff, 52'h8000000000000} : {f[31], 11'h7ff, 52'd0};
        else
            d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:52] == 11'h7ff)
            return (d[51:0] != 0) ? 32'h7fc00000 : {d[63], 8'hff, 23'd0};
        if (d[62:52] == 11'h000)
            return {d[63], 31'd0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    // behavioural adder: get_a, get_b, then present z, with random ack/latency
    initial begin
        int rs = 0;
        int zdly = 0;
        logic a_x = 1'b0, b_x = 1'b0, z_x = 1'b0;
        logic [31:0] a_lat = 0, b_lat = 0, ra = 0, rb = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rs = 0; a_x = 0; b_x = 0; z_x = 0;
                add_a_ack = 0; add_b_ack = 0; add_z_strb = 0; add_z = 0;
            end else begin
                if (a_x) begin ra = a_lat; add_a_ack = 0; rs = 1; a_x = 0; end
                if (b_x) begin rb = b_lat; add_b_ack = 0; rs = 2; zdly = $urandom_range(0, 3); b_x = 0; end
                if (z_x) begin add_z_strb = 0; rs = 0; z_x = 0; end
                case (rs)
                    0: begin
                        add_a_ack = ($urandom_range(0, 2) != 0);
                        if (add_a_ack && add_a_strb) begin a_x = 1; a_lat = add_a; end
                    end
                    1: begin
                        add_b_ack = ($urandom_range(0, 2) != 0);
                        if (add_b_ack && add_b_strb) begin b_x = 1; b_lat = add_b; end
                    end
                    2: begin
                        if (zdly > 0) zdly--;
                        else begin add_z = fadd(ra, rb); add_z_strb = 1; rs = 3; end
                    end
                    default: ;
                endcase
                if (rs == 3 && add_z_strb && add_z_ack) z_x = 1;
            end
        end
    end

    // sum sink + scoreboard: pops and compares on every sum transfer, checks hold under backpressure
    initial begin
        logic          prev_wait = 1'b0;
        logic [SW-1:0] saved = '0;
        logic [SW-1:0] e, m;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (!bp_mode) sum_ack = 0;
                prev_wait = 0;
            end else begin
                if (prev_wait)
                    check("sum_hold", {sum_strb, sum_z, sum_count}, {1'b1, saved});
                if (!bp_mode) sum_ack = ($urandom_range(0, 2) == 0);
                if (sum_strb && sum_ack) begin
                    if (exp_q.size() == 0) check("sum_extra", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        m = msk_q.pop_front();
                        check("sum", {sum_z, sum_count} & m, e & m);
                    end
                    prev_wait = 0;
                end else if (sum_strb) begin
                    prev_wait = 1;
                    saved = {sum_z, sum_count};
                end else prev_wait = 0;
            end
        end
    end

    // driver tasks (called in the negedge phase)
    task automatic push_exp(input logic [31:0] s, input int n, input logic [31:0] smask);
        exp_q.push_back({s, CNT_W'(n)});
        msk_q.push_back({smask, {CNT_W{1'b1}}});
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int guard = 0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        in_data = d; in_last = l; in_strb = 1;
        while (!in_ack && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ack) check("in_timeout", 1, 0);
        @(negedge clk);
        in_strb = 0;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("drain", 64'(exp_q.size()), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_strb"}, {in_ack, add_a_strb, add_b_strb, add_z_ack, sum_strb}, 0);
        check({tag, "_a"}, add_a, 0);
        check({tag, "_b"}, add_b, 0);
        check({tag, "_sum"}, {sum_z, sum_count}, 0);
    endtask

    initial begin
        int n, tot, v, guard;

        rst = 1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 0;

        // single element
        push_exp(32'h3F800000, 1, 32'hFFFFFFFF);
        send(32'h3F800000, 1);
        drain();

        // 1 + 2 + 3 + 4 = 10
        push_exp(32'h41200000, 4, 32'hFFFFFFFF);
        send(32'h3F800000, 0); send(32'h40000000, 0);
        send(32'h40400000, 0); send(32'h40800000, 1);
        drain();

        // cancellation to +0, then a fresh vector proves acc/count were cleared
        push_exp(32'h00000000, 2, 32'hFFFFFFFF);
        send(32'h3F800000, 0); send(32'hBF800000, 1);
        push_exp(32'h40000000, 1, 32'hFFFFFFFF);
        send(32'h40000000, 1);
        drain();

        // Inf propagation and Inf + -Inf = NaN (exponent all ones, quiet bit set)
        push_exp(32'h7F800000, 2, 32'hFFFFFFFF);
        send(32'h7F800000, 0); send(32'h3F800000, 1);
        push_exp(32'h7FC00000, 2, 32'h7FC00000);
        send(32'h7F800000, 0); send(32'hFF800000, 1);
        drain();

        // sum backpressure with a pending element upstream
        @(posedge clk); #1;
        bp_mode = 1; sum_ack = 0;
        @(negedge clk);
        push_exp(32'h40A00000, 1, 32'hFFFFFFFF);
        send(32'h40A00000, 1);
        push_exp(32'h3F800000, 1, 32'hFFFFFFFF);
        in_data = 32'h3F800000; in_last = 1; in_strb = 1;
        guard = 0;
        while (!sum_strb && guard < 500) begin @(negedge clk); guard++; end
        check("bp_strb_seen", sum_strb, 1);
        repeat (20) begin
            @(negedge clk);
            check("bp_hold", {sum_strb, in_ack, sum_z}, {1'b1, 1'b0, 32'h40A00000});
        end
        @(posedge clk); #1; sum_ack = 1;
        @(negedge clk);
        @(posedge clk); #1; sum_ack = 0;
        @(negedge clk);
        check("bp_after_xfer", {sum_strb, in_ack}, 0);
        @(negedge clk);
        check("bp_in_ack_rise", in_ack, 1);
        @(posedge clk); #1;
        in_strb = 0; bp_mode = 0;
        @(negedge clk);
        drain();

        // count wraps modulo 2^CNT_W: 17 elements -> count 1, sum 17.0
        push_exp(32'h41880000, 1, 32'hFFFFFFFF);
        for (int i = 0; i < 17; i++) send(32'h3F800000, (i == 16));
        drain();

        // random small-integer vectors
        for (int k = 0; k < 4; k++) begin
            n = $urandom_range(1, 6);
            tot = 0;
            for (int i = 0; i < n; i++) tot += 0;
            for (int i = 0; i < n; i++) begin
                v = $urandom_range(1, 15);
                tot += v;
                if (i == n - 1) push_exp(r2f($itor(tot)), n, 32'hFFFFFFFF);
                send(r2f($itor(v)), (i == n - 1));
            end
        end
        drain();

        // reset while the third element is in GET_Z
        send(32'h3F800000, 0); send(32'h40000000, 0);
        send(32'h40800000, 1);
        guard = 0;
        while (!add_z_ack && guard < 500) begin @(negedge clk); guard++; end
        check("mid_get_z_seen", add_z_ack, 1);
        rst = 1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rst = 0;
        push_exp(32'h40400000, 1, 32'hFFFFFFFF);
        send(32'h40400000, 1);
        drain();

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/softmax_sum_acc.md
Name: softmax_sum_acc

Overview:
- Accumulation sequencer for the softmax denominator.
- Accepts a stream of single-precision exponent values terminated by a last flag.
- For each element it drives the floating-point adder's strobe/ack ports with (running sum, element) and captures the adder result as the new running sum.
- After the last element it presents the final sum and element count downstream, to the divider stage.

Parameters:
- CNT_W, 16, width of the element counter reported with the sum.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset; the adder shares this rst.
- in_data  input  32  IEEE-754 single element.
- in_last  input  1  qualifies in_data as the final element of a vector.
- in_strb  input  1  upstream data valid.
- in_ack  output  1  element accepted; transfer on in_strb && in_ack at posedge.
- add_a  output  32  running sum to adder input_a.
- add_a_strb  output  1  to adder input_a_strb.
- add_a_ack  input  1  from adder input_a_ack.
- add_b  output  32  element to adder input_b.
- add_b_strb  output  1  to adder input_b_strb.
- add_b_ack  input  1  from adder input_b_ack.
- add_z  input  32  adder output_z.
- add_z_strb  input  1  adder output_z_strb.
- add_z_ack  output  1  to adder output_z_ack.
- sum_z  output  32  final sum.
- sum_count  output  CNT_W  number of elements summed.
- sum_strb  output  1  sum valid.
- sum_ack  input  1  downstream accept; transfer on sum_strb && sum_ack.

Behaviour:
- Reset values:
  - state = GET_X.
  - All strb/ack outputs = 0.
  - acc = 32'h00000000 (+0).
  - count = 0.
  - add_a, add_b, sum_z, sum_count = 0.
- Handshake rules, all ports:
  - A transfer occurs on the posedge where strb and ack are both 1.
  - The strb side holds its data stable until that transfer.
  - The strb side deasserts strb on the same edge as the transfer, using the registered update.
- State GET_X:
  - in_ack <= 1.
  - On transfer: latch x <= in_data, last_r <= in_last; in_ack <= 0; go to SEND_A.
- State SEND_A:
  - add_a <= acc, add_a_strb <= 1.
  - On add_a_strb && add_a_ack: add_a_strb <= 0; go to SEND_B.
- State SEND_B:
  - add_b <= x, add_b_strb <= 1.
  - On add_b_strb && add_b_ack: add_b_strb <= 0; go to GET_Z.
- State GET_Z:
  - add_z_ack <= 1.
  - On add_z_strb && add_z_ack:
    - acc <= add_z; count <= count + 1; add_z_ack <= 0.
    - If last_r: go to PUT_SUM. Else go to GET_X.
- State PUT_SUM:
  - sum_z <= acc, sum_count <= count, sum_strb <= 1.
  - On sum_strb && sum_ack:
    - sum_strb <= 0; acc <= 0; count <= 0; go to GET_X.
- Arithmetic:
  - Every element, including the first, passes through the adder; there is no bypass. Results are therefore bit-exact with adder semantics: +0 + (-0) = +0, and first sum = x for any nonzero x.
  - NaN and Inf propagate per the adder and are not special-cased here.
- Ordering:
  - a is always presented before b, matching the adder's get_a → get_b order.
  - Only one add is in flight; there is no overlap.
- Throughput: one element per adder round trip. in_ack is low in every state except GET_X.
- Backpressure: while sum_ack = 0, hold sum_z, sum_count and sum_strb stable and accept no new input.
- Count overflow: count wraps modulo 2^CNT_W. No saturation and no flag.
- in_last on the first element: a single-element vector, with sum = adder(+0, x), count = 1.
- Empty vector: not supported. Upstream always sends at least one element, with in_last on the final one.
- Reset mid-operation (any state):
  - Immediately return to reset values, dropping any partial sum.
  - Because the adder shares rst, no adder transaction is left half-complete.
- Any strb/ack input that arrives in a non-matching state is ignored.

Test Plan:
- Single element 0x3F800000 with in_last=1 → sum_z = 0x3F800000, sum_count = 1; sum_strb held until sum_ack.
- Elements 1.0, 2.0, 3.0, 4.0 (0x3F800000, 0x40000000, 0x40400000, 0x40800000), last on the 4th → sum_z = 0x41200000, sum_count = 4.
- Elements +1.0, -1.0 (0xBF800000), last → sum_z = 0x00000000, count = 2; then a second vector 0x40000000 (last) → 0x40000000, count = 1, confirming acc/count were cleared.
- Elements 0x7F800000, 0x3F800000 → sum_z = 0x7F800000; elements 0x7F800000, 0xFF800000 → NaN with exponent 0xFF and bit 22 = 1.
- sum_ack held 0 for 20 cycles with in_strb = 1 → sum_z and sum_strb stable, in_ack stays 0; on sum_ack = 1 the transfer happens, and in_ack rises the next cycle.
- rst pulsed while in GET_Z after 2 of 3 elements → all outputs return to reset values; a new vector 0x40400000 (last) → sum 0x40400000, count 1.
